// File: rtl/ddr_half_word_gearbox_pkg.sv
// Shared types and constants for the 2x-domain half-word gearbox.
package ddr_sync_pkg;

  localparam int unsigned GB_SRC_WIDTH  = 32;
  localparam int unsigned GB_CTRL_WIDTH = GB_SRC_WIDTH / 8;
  localparam int unsigned GB_DEPTH      = 2;
  localparam logic [15:0] GB_CNT_MAX    = 16'hFFFF;

  // One buffered input word with its per-byte K flags
  typedef struct packed {
    logic [GB_SRC_WIDTH-1:0]  data;
    logic [GB_CTRL_WIDTH-1:0] ctrl;
    logic                     half_only;
  } gb_entry_t;

  // Which emitted half of the head word is on the output
  typedef enum logic {
    SEL_FIRST  = 1'b0,
    SEL_SECOND = 1'b1
  } gb_sel_e;

endpackage

// File: rtl/ddr_half_word_gearbox_fifo.sv
// Two-entry registered FIFO; ready on the input side depends on occupancy only.
module ddr_sync_skid_fifo
  import ddr_sync_pkg::*;
#(
  parameter type T = gb_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T           r_mem [GB_DEPTH];
  logic [1:0] r_count;
  logic       r_head;
  logic       w_push;
  logic       w_pop;
  logic       w_wr_idx;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_head];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Tail slot is the head when empty, the other slot when one entry is held
  assign w_wr_idx  = r_head ^ r_count[0];

  // Storage, head pointer and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '{default: '0};
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      if (w_push) r_mem[w_wr_idx] <= in_data;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_half_word_gearbox.sv
// 2:1 width gearbox: buffers words in a 2-entry FIFO and emits them as half-words.
module ddr_half_word_gearbox
  import ddr_sync_pkg::*;
#(
  parameter int SRC_WIDTH  = 32,
  parameter int DST_WIDTH  = SRC_WIDTH / 2,
  parameter int CTRL_WIDTH = SRC_WIDTH / 8,
  parameter int PHASE      = 0
) (
  input  logic                    local_2x_clk,
  input  logic                    local_2x_reset,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [SRC_WIDTH-1:0]    src_data,
  input  logic [CTRL_WIDTH-1:0]   src_ctrl,
  input  logic                    src_half_only,
  output logic                    dst_valid,
  input  logic                    dst_ready,
  output logic [DST_WIDTH-1:0]    dst_data,
  output logic [CTRL_WIDTH/2-1:0] dst_ctrl,
  output logic                    dst_first,
  output logic                    dst_last,
  output logic [15:0]             word_count
);

  localparam int HALF_CTRL = CTRL_WIDTH / 2;

  typedef struct packed {
    logic [SRC_WIDTH-1:0]  data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  half_only;
  } entry_t;

  entry_t      w_in;
  entry_t      w_head;
  logic        w_head_valid;
  logic        w_half_hi;
  logic        w_last;
  logic        w_beat;
  gb_sel_e     r_sel;
  gb_sel_e     w_sel_next;
  logic [15:0] r_word_count;

  assign w_in = '{data: src_data, ctrl: src_ctrl, half_only: src_half_only};

  // The FIFO pops only on the beat that completes a word
  ddr_sync_skid_fifo #(
    .T (entry_t)
  ) u_fifo (
    .clk       (local_2x_clk),
    .rst       (local_2x_reset),
    .in_valid  (src_valid),
    .in_ready  (src_ready),
    .in_data   (w_in),
    .out_valid (w_head_valid),
    .out_ready (dst_ready && w_last),
    .out_data  (w_head)
  );

  assign w_half_hi = (r_sel == SEL_SECOND) ^ (PHASE != 0);
  assign w_last    = (r_sel == SEL_SECOND) || w_head.half_only;
  assign w_beat    = w_head_valid && dst_ready;

  // Outputs are gated by valid so an empty gearbox presents all zeros
  assign dst_valid  = w_head_valid;
  assign dst_data   = !w_head_valid ? '0 :
                      w_half_hi ? w_head.data[SRC_WIDTH-1:DST_WIDTH] : w_head.data[DST_WIDTH-1:0];
  assign dst_ctrl   = !w_head_valid ? '0 :
                      w_half_hi ? w_head.ctrl[CTRL_WIDTH-1:HALF_CTRL] : w_head.ctrl[HALF_CTRL-1:0];
  assign dst_first  = w_head_valid && (r_sel == SEL_FIRST);
  assign dst_last   = w_head_valid && w_last;
  assign word_count = r_word_count;

  // Half select: advance to the second half, or back to first once a word completes
  always_comb begin
    w_sel_next = r_sel;
    if (w_beat) w_sel_next = w_last ? SEL_FIRST : SEL_SECOND;
  end

  // Half select register
  always_ff @(posedge local_2x_clk) begin
    if (local_2x_reset) r_sel <= SEL_FIRST;
    else                r_sel <= w_sel_next;
  end

  // Saturating count of completed words
  always_ff @(posedge local_2x_clk) begin
    if (local_2x_reset)
      r_word_count <= '0;
    else if (w_beat && w_last && (r_word_count != GB_CNT_MAX))
      r_word_count <= r_word_count + 16'd1;
  end

endmodule

// File: tb/tb_ddr_half_word_gearbox.sv
// Self-checking bench: two gearboxes (PHASE 0 and 1) share stimulus and are
// compared every cycle against a beat-queue reference model.
module tb_ddr_half_word_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv;
  logic        dr;
  logic [31:0] sd;
  logic [3:0]  sc;
  logic        sho;

  logic        rdy0, val0, f0, l0;
  logic [15:0] d0, wc0;
  logic [1:0]  c0;
  logic        rdy1, val1, f1, l1;
  logic [15:0] d1, wc1;
  logic [1:0]  c1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_half_word_gearbox #(.SRC_WIDTH(32), .PHASE(0)) u_dut_p0 (
    .local_2x_clk(clk), .local_2x_reset(rst),
    .src_valid(sv), .src_ready(rdy0), .src_data(sd), .src_ctrl(sc), .src_half_only(sho),
    .dst_valid(val0), .dst_ready(dr), .dst_data(d0), .dst_ctrl(c0),
    .dst_first(f0), .dst_last(l0), .word_count(wc0)
  );

  ddr_half_word_gearbox #(.SRC_WIDTH(32), .PHASE(1)) u_dut_p1 (
    .local_2x_clk(clk), .local_2x_reset(rst),
    .src_valid(sv), .src_ready(rdy1), .src_data(sd), .src_ctrl(sc), .src_half_only(sho),
    .dst_valid(val1), .dst_ready(dr), .dst_data(d1), .dst_ctrl(c1),
    .dst_first(f1), .dst_last(l1), .word_count(wc1)
  );

  // Reference model: the ordered list of beats still owed, per phase
  typedef struct {
    logic [15:0] d;
    logic [1:0]  c;
    logic        f;
    logic        l;
  } beat_t;

  beat_t bq0[$];
  beat_t bq1[$];
  int    words_in = 0;
  int    exp_wc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] c, input bit hi,
                               input bit f, input bit l);
    beat_t b;
    b.d = hi ? d[31:16] : d[15:0];
    b.c = hi ? c[3:2] : c[1:0];
    b.f = f;
    b.l = l;
    return b;
  endfunction

  task automatic model_push(input logic [31:0] d, input logic [3:0] c, input logic ho);
    if (ho) begin
      bq0.push_back(mk(d, c, 1'b0, 1'b1, 1'b1));
      bq1.push_back(mk(d, c, 1'b1, 1'b1, 1'b1));
    end else begin
      bq0.push_back(mk(d, c, 1'b0, 1'b1, 1'b0));
      bq0.push_back(mk(d, c, 1'b1, 1'b0, 1'b1));
      bq1.push_back(mk(d, c, 1'b1, 1'b1, 1'b0));
      bq1.push_back(mk(d, c, 1'b0, 1'b0, 1'b1));
    end
    words_in++;
  endtask

  task automatic chk_beat(input string tag, input beat_t e, input bit v,
                          input logic [15:0] d, input logic [1:0] c, input logic f, input logic l);
    chk({tag, "_data"},  {16'h0, d},  v ? {16'h0, e.d} : 32'h0);
    chk({tag, "_ctrl"},  {30'h0, c},  v ? {30'h0, e.c} : 32'h0);
    chk({tag, "_first"}, {31'h0, f},  v ? {31'h0, e.f} : 32'h0);
    chk({tag, "_last"},  {31'h0, l},  v ? {31'h0, e.l} : 32'h0);
  endtask

  // One clock: drive at negedge, check registered outputs, update model at posedge
  task automatic cycle(input logic r, input logic v, input logic ready,
                       input logic [31:0] d, input logic [3:0] c, input logic ho,
                       output bit accepted);
    bit    e_rdy, e_val;
    beat_t e0, e1, popped;
    rst = r; sv = v; dr = ready; sd = d; sc = c; sho = ho;
    #1;
    e_rdy = (words_in != 2);
    e_val = (bq0.size() != 0);
    e0 = '{default: '0};
    e1 = '{default: '0};
    if (e_val) begin e0 = bq0[0]; e1 = bq1[0]; end
    chk("p0_src_ready", {31'h0, rdy0}, {31'h0, e_rdy});
    chk("p1_src_ready", {31'h0, rdy1}, {31'h0, e_rdy});
    chk("p0_dst_valid", {31'h0, val0}, {31'h0, e_val});
    chk("p1_dst_valid", {31'h0, val1}, {31'h0, e_val});
    chk("p0_word_count", {16'h0, wc0}, exp_wc);
    chk("p1_word_count", {16'h0, wc1}, exp_wc);
    chk_beat("p0", e0, e_val, d0, c0, f0, l0);
    chk_beat("p1", e1, e_val, d1, c1, f1, l1);
    accepted = !r && v && e_rdy;
    @(posedge clk);
    if (r) begin
      bq0.delete();
      bq1.delete();
      words_in = 0;
      exp_wc   = 0;
    end else begin
      if (e_val && ready) begin
        popped = bq0.pop_front();
        void'(bq1.pop_front());
        if (popped.l) begin
          words_in--;
          if (exp_wc != 32'hFFFF) exp_wc++;
        end
      end
      if (accepted) model_push(d, c, ho);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ready);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, ready, 32'h0, 4'h0, 1'b0, a);
  endtask

  initial begin
    bit          acc;
    int          tries;
    logic [31:0] wd;
    logic [3:0]  wct;
    logic        who;

    rst = 1'b1; sv = 1'b0; dr = 1'b0; sd = '0; sc = '0; sho = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then one full word
    idle(1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'hA1B2C3D4, 4'b0001, 1'b0, acc);
    idle(3, 1'b1);
    chk("single_word_count", {16'h0, wc0}, 32'd1);

    // half_only word followed directly by a full word
    cycle(1'b0, 1'b1, 1'b1, 32'h0000BEEF, 4'b0011, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b1, 32'h12345678, 4'b1000, 1'b0, acc);
    idle(3, 1'b1);

    // Backpressure: two accepted, third stalls until space frees
    cycle(1'b0, 1'b1, 1'b0, 32'hA1B2C3D4, 4'b0001, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b0, 32'h55AA66BB, 4'b0110, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b0, 32'h0F1E2D3C, 4'b1001, 1'b0, acc);
    chk("bp_third_refused", {31'h0, acc}, 32'd0);
    chk("bp_stall_data", {16'h0, d0}, 32'h0000C3D4);
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 10) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h0F1E2D3C, 4'b1001, 1'b0, acc);
      tries++;
    end
    chk("bp_third_accepted", {31'h0, acc}, 32'd1);
    idle(8, 1'b1);

    // Streaming with random downstream stalls
    wd = $urandom; wct = 4'($urandom); who = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), wd, wct, who, acc);
      if (acc) begin
        wd = $urandom; wct = 4'($urandom); who = ($urandom_range(0, 3) == 0);
      end
    end
    idle(8, 1'b1);

    // Reset after the first half of a word has been taken
    cycle(1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 4'b0101, 1'b0, acc);
    idle(1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, acc);
    idle(1, 1'b0);
    chk("reset_word_count", {16'h0, wc0}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h89ABCDEF, 4'b0010, 1'b0, acc);
    chk("post_reset_first", {31'h0, f0}, 32'd1);
    idle(4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_half_word_gearbox.md
# ddr_half_word_gearbox

Single-clock 2:1 width gearbox in the 2x domain. It takes 32-bit words with per-byte control flags over a valid/ready handshake and emits them as 16-bit half-words, with a selectable half order. It is the flow-controlled, back-pressurable counterpart to the free-running 1x→2x split path. It sits between 1x-generated word streams, already moved into the 2x domain, and 2x-rate lane logic that may stall.

## Interface

Parameters:
- SRC_WIDTH, 32, input word width; must be a multiple of 16.
- DST_WIDTH, SRC_WIDTH/2, output half-word width.
- CTRL_WIDTH, SRC_WIDTH/8, one control (K) flag per input byte.
- PHASE, 0, half order: 0 emits low half first; 1 emits high half first.

Ports:
- local_2x_clk, input, 1, sole clock; all logic is on its rising edge.
- local_2x_reset, input, 1, synchronous reset, active-high.
- src_valid, input, 1, input word valid.
- src_ready, output, 1, gearbox can accept a word this cycle.
- src_data, input, SRC_WIDTH, input word.
- src_ctrl, input, CTRL_WIDTH, per-byte control flags for src_data.
- src_half_only, input, 1, only the first-emitted half is meaningful; the second half is dropped.
- dst_valid, output, 1, half-word valid.
- dst_ready, input, 1, downstream accepts the half-word.
- dst_data, output, DST_WIDTH, current half-word.
- dst_ctrl, output, CTRL_WIDTH/2, control flags for dst_data.
- dst_first, output, 1, dst_data is the first-emitted half of its word.
- dst_last, output, 1, dst_data is the final half of its word: the second half, or the first half when half_only is set.
- word_count, output, 16, saturating count of fully emitted words.

## Operation

- Storage is a 2-entry word FIFO. Each entry holds {data, ctrl, half_only}. Control state is occupancy count (0..2), head pointer (1 bit) and half select sel (1 bit).
- Push: src_valid && src_ready. src_ready = (count != 2), derived from registers only, with no combinational path from dst_ready.
- Output: dst_valid = (count != 0).
  - Physical half emitted = sel ^ PHASE, where 0 means bits [DST_WIDTH-1:0] and 1 means the upper half.
  - dst_ctrl is taken from the matching half of ctrl.
  - dst_first = (sel == 0).
  - dst_last = sel || head.half_only.
- Pop: on dst_valid && dst_ready && dst_last. The head advances, sel returns to 0, and word_count increments, saturating at 16'hFFFF.
- On dst_valid && dst_ready && !dst_last: sel flips to 1 and the head is unchanged.
- Simultaneous push and pop at count==1: count stays 1 and the new word becomes head next cycle.
- At count==2 no push is possible.
- At count==0 dst_ready is ignored.
- dst_valid, once asserted, stays asserted and dst_data/dst_ctrl/dst_first/dst_last stay stable until accepted.
- Reset, including mid-word: count=0, sel=0, head=0, all storage=0, word_count=0. All outputs therefore read 0, and src_ready reads 1 starting the cycle after reset deasserts. Any in-flight word is discarded.

## Timing

- Latency: a word pushed in cycle N presents its first half in cycle N+1. This is registered storage with no bypass.
- Throughput with dst_ready held high: one half-word per cycle. Full words drain one per 2 cycles; half_only words drain one per cycle.
- Continuous src_valid with dst_ready high: src_ready toggles so the FIFO never overflows. Sustained input rate is 1 word per 2 cycles.
- word_count updates in the cycle after the popping handshake.

## Structure

- Package ddr_sync_pkg holds:
  - the typedef packed struct gb_entry_t {data, ctrl, half_only};
  - localparam GB_DEPTH = 2;
  - localparam GB_CNT_MAX = 16'hFFFF.
- Sub-module ddr_sync_skid_fifo: a 2-entry registered FIFO with valid/ready on both sides, sync active-high reset, parameterized on gb_entry_t. The gearbox adds the sel/PHASE muxing and word_count on top of it.

## Test plan

- Reset then single word: data=32'hA1B2C3D4, ctrl=4'b0001, PHASE=0, dst_ready=1 → cycle N+1 emits 16'hC3D4 with ctrl 2'b01 and first=1; cycle N+2 emits 16'hA1B2 with ctrl 2'b00 and last=1; word_count=1.
- PHASE=1, same word → emits 16'hA1B2 then 16'hC3D4, with first/last flags matching the order.
- half_only word 32'h0000BEEF, PHASE=0 → exactly one beat 16'hBEEF with first=1 and last=1; the next word's first half follows on the next cycle.
- Backpressure: push 3 words with dst_ready=0 → src_ready drops after 2 accepts and dst_data stays 16'hC3D4 stable. Then raise dst_ready → 6 beats in order with no loss or duplication.
- Streaming: src_valid held 100 cycles, dst_ready random at 50% → scoreboard matches all halves in order, word_count equals words popped, and src_ready never asserts at count==2.
- Reset mid-word: assert reset after the first half is accepted → next cycle dst_valid=0, word_count=0, src_ready=1. The next pushed word starts at first=1.
